// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetches instructions for decode. Issues one instruction-memory read at a
// time from the current PC, advances the PC once per accepted request, buffers
// returned words in a small FIFO and hands them to decode over valid/ready.
// A redirect (same cycle as the PC jump) empties the FIFO and discards any
// response still in flight.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   pc_i             current PC
//   pc_advance_o     PC increment strobe, high in the request-accept cycle
//   redirect_i       flush, coincident with the PC jump
//   mem_req_valid_o  read request valid
//   mem_req_ready_i  memory accepts the request
//   mem_req_addr_o   read address
//   mem_rsp_valid_i  read data valid (single-cycle pulse, no backpressure)
//   mem_rsp_data_i   read data
//   instr_valid_o    FIFO head valid
//   instr_ready_i    decode accepts the head
//   instr_o          instruction at the FIFO head
//   instr_pc_o       address of instr_o
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4   // power of two, at least 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WIDTH-1:0]       pc_i,
    output logic                   pc_advance_o,
    input  logic                   redirect_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [WIDTH-1:0]       mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0]       instr_pc_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,   // no request outstanding
        StWait,   // request outstanding, response will be kept
        StDrain   // request outstanding, response will be discarded
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] req_pc_q, req_pc_d;

    // Low during reset and for the first cycle after it, so every output
    // reads 0 while reset is applied without using rst_ni as plain logic.
    logic active_q, active_d;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic [WIDTH-1:0]       pc_mem_q   [DEPTH];
    logic [INSTR_WIDTH-1:0] data_mem_q [DEPTH];

    logic handshake;
    logic push;
    logic pop;
    logic fifo_full;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            req_pc_q <= '0;
            active_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            active_q <= active_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: the outputs are masked while it is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            data_mem_q[wr_ptr_q] <= mem_rsp_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        active_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d  = StWait;
                    req_pc_d = pc_i;
                end
            end
            StWait: begin
                // A response coinciding with a redirect is dropped by the
                // push gating; either way nothing is outstanding afterwards.
                if (mem_rsp_valid_i) begin
                    state_d = StIdle;
                end else if (redirect_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_rsp_valid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect_i) begin
            // Flush wins over any push or pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_full = (count_q == FullCount);

        // Valid only depends on state, count and redirect, so it stays up with
        // a stable address until accepted unless a redirect intervenes.
        mem_req_valid_o = active_q && (state_q == StIdle) && !redirect_i && !fifo_full;
        mem_req_addr_o  = active_q ? pc_i : '0;
        handshake       = mem_req_valid_o && mem_req_ready_i;
        pc_advance_o    = handshake;

        // Only WAIT enqueues, and WAIT is entered with a free slot, so the
        // FIFO cannot overflow.
        push = (state_q == StWait) && mem_rsp_valid_i && !redirect_i;

        instr_valid_o = (count_q != '0);
        pop           = instr_valid_o && instr_ready_i && !redirect_i;
        instr_o       = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
        instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_i;
    logic        pc_advance_o;
    logic        redirect_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    always #5 clk_i = ~clk_i;

    instruction_fetch_unit #(
        .WIDTH       (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pc_i            (pc_i),
        .pc_advance_o    (pc_advance_o),
        .redirect_i      (redirect_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    exp_t exp_q[$];
    int   pop_times[$];
    exp_t mon_e;

    // Environment controls
    logic [31:0] redir_target;
    bit          hold_en;
    logic [31:0] hold_addr;
    bit          mem_flush;
    int          accepts;
    int          advs;

    // Model state
    bit          pend_valid;
    logic [31:0] pend_addr;
    bit          s_hs, s_adv, s_redir, s_hold_en, s_rst, s_flush;
    logic [31:0] s_addr, s_tgt, s_hold_addr;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc);
        exp_q.push_back(exp_t'{pc: pc, data: pc ^ 32'hFFFF_FFFF});
    endtask

    task automatic do_reset(input bit flush);
        mem_flush = flush;
        rst_ni    = 1'b0;
        accepts   = 0;
        advs      = 0;
        repeat (3) cyc();
        rst_ni = 1'b1;
    endtask

    task automatic drain(input int budget);
        instr_ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (exp_q.size() == 0) break;
        end
        instr_ready_i = 1'b0;
        chk("drain_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // PC (stride 1, reset 0) and zero-wait memory: samples just before each
    // rising edge, applies the effect just after it.
    initial begin
        pc_i            = '0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        pend_valid      = 1'b0;
        pend_addr       = '0;
        forever begin
            @(negedge clk_i);
            #4;
            s_hs        = mem_req_valid_o && mem_req_ready_i;
            s_addr      = mem_req_addr_o;
            s_adv       = pc_advance_o;
            s_redir     = redirect_i;
            s_tgt       = redir_target;
            s_hold_en   = hold_en;
            s_hold_addr = hold_addr;
            s_rst       = rst_ni;
            s_flush     = mem_flush;
            if (s_hs) accepts++;
            if (s_adv) advs++;
            @(posedge clk_i);
            #1;
            if (!s_rst)       pc_i = '0;
            else if (s_redir) pc_i = s_tgt;
            else if (s_adv)   pc_i = pc_i + 1;
            if (!s_rst && s_flush) pend_valid = 1'b0;
            if (s_hs) begin
                pend_valid = 1'b1;
                pend_addr  = s_addr;
            end
            mem_rsp_valid_i = 1'b0;
            if (pend_valid && !(s_hold_en && pend_addr == s_hold_addr)) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = pend_addr ^ 32'hFFFF_FFFF;
                pend_valid      = 1'b0;
            end
        end
    end

    // Monitor: every decode transfer is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && instr_valid_o && instr_ready_i && !redirect_i) begin
                pop_times.push_back(cyc_cnt);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h data %h required none",
                             instr_pc_o, instr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr_pc", instr_pc_o, mon_e.pc);
                    chk("instr_data", instr_o, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni          = 1'b0;
        instr_ready_i   = 1'b1;
        mem_req_ready_i = 1'b1;
        redirect_i      = 1'b0;
        redir_target    = '0;
        hold_en         = 1'b0;
        hold_addr       = '0;
        mem_flush       = 1'b1;
        accepts         = 0;
        advs            = 0;

        // 1: reset state, then free run at one instruction per 2 cycles
        repeat (2) cyc();
        @(negedge clk_i);
        chk("rst_req_valid", mem_req_valid_o, 0);
        chk("rst_pc_adv", pc_advance_o, 0);
        chk("rst_instr_valid", instr_valid_o, 0);
        chk("rst_req_addr", mem_req_addr_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        cyc();
        rst_ni = 1'b1;
        pop_times.delete();
        for (int i = 0; i < 4; i++) expect_push(i);
        drain(40);
        chk("pop_count", pop_times.size(), 4);
        if (pop_times.size() >= 4) begin
            for (int i = 1; i < 4; i++) chk("pop_gap", pop_times[i] - pop_times[i-1], 2);
        end
        @(negedge clk_i);
        chk("pc_vs_accepts", pc_i, accepts);
        chk("adv_vs_accepts", advs, accepts);
        cyc();

        // 2: decode stalled from reset, FIFO fills, PC holds, then drains
        instr_ready_i = 1'b0;
        do_reset(1'b1);
        repeat (12) cyc();
        @(negedge clk_i);
        chk("full_no_req", mem_req_valid_o, 0);
        chk("full_pc_hold", pc_i, 4);
        chk("full_no_adv", pc_advance_o, 0);
        chk("full_accepts", accepts, 4);
        for (int i = 0; i < 5; i++) expect_push(i);
        cyc();
        drain(40);

        // 3: memory not ready, request held stable
        mem_req_ready_i = 1'b0;
        do_reset(1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_req_valid", mem_req_valid_o, 1);
            chk("stall_req_addr", mem_req_addr_o, 0);
            chk("stall_no_adv", pc_advance_o, 0);
            chk("stall_pc", pc_i, 0);
            cyc();
        end
        mem_req_ready_i = 1'b1;
        expect_push(0);
        drain(20);

        // 4: redirect in WAIT for address 5 with two entries queued
        hold_addr = 32'd5;
        hold_en   = 1'b1;
        do_reset(1'b1);
        repeat (12) cyc();
        for (int i = 0; i < 3; i++) expect_push(i);
        drain(20);
        repeat (3) cyc();
        @(negedge clk_i);
        chk("wait_instr_valid", instr_valid_o, 1);
        chk("wait_no_req", mem_req_valid_o, 0);
        chk("wait_pc", pc_i, 6);
        cyc();
        redirect_i   = 1'b1;
        redir_target = 32'hABCD_1234;
        @(negedge clk_i);
        chk("redir_no_adv", pc_advance_o, 0);
        chk("redir_no_req", mem_req_valid_o, 0);
        cyc();
        redirect_i = 1'b0;
        hold_en    = 1'b0;
        @(negedge clk_i);
        chk("redir_flush_valid", instr_valid_o, 0);
        cyc();
        @(negedge clk_i);
        chk("drain_no_req", mem_req_valid_o, 0);
        cyc();
        @(negedge clk_i);
        chk("redir_req_valid", mem_req_valid_o, 1);
        chk("redir_req_addr", mem_req_addr_o, 32'hABCD_1234);
        expect_push(32'hABCD_1234);
        drain(20);

        // 5: redirect coincident with the response
        hold_addr = 32'd0;
        hold_en   = 1'b1;
        do_reset(1'b1);
        repeat (4) cyc();
        @(negedge clk_i);
        chk("coinc_wait_no_req", mem_req_valid_o, 0);
        cyc();
        hold_en = 1'b0;
        cyc();
        redirect_i   = 1'b1;
        redir_target = 32'h0000_0100;
        @(negedge clk_i);
        chk("coinc_no_adv", pc_advance_o, 0);
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("coinc_flush_valid", instr_valid_o, 0);
        chk("coinc_req_valid", mem_req_valid_o, 1);
        chk("coinc_req_addr", mem_req_addr_o, 32'h0000_0100);
        expect_push(32'h0000_0100);
        drain(20);

        // 6: reset mid-WAIT for address 2, late response after release
        hold_addr = 32'd2;
        hold_en   = 1'b1;
        do_reset(1'b1);
        repeat (10) cyc();
        @(negedge clk_i);
        chk("mid_wait_valid", instr_valid_o, 1);
        chk("mid_wait_no_req", mem_req_valid_o, 0);
        cyc();
        mem_req_ready_i = 1'b0;
        do_reset(1'b0);
        cyc();
        hold_en = 1'b0;
        repeat (3) cyc();
        @(negedge clk_i);
        chk("stray_ignored", instr_valid_o, 0);
        cyc();
        mem_req_ready_i = 1'b1;
        expect_push(0);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
